// File: rtl/fe_pkg.sv
// Front-end shared types: RV32I opcode encodings, multi-cycle control states
// and trap causes, plus opcode classification helpers.
package fe_pkg;

   typedef enum logic [6:0] {
      OPC_R_TYPE = 7'b0110011,
      OPC_I_TYPE = 7'b0010011,
      OPC_I_LOAD = 7'b0000011,
      OPC_S_TYPE = 7'b0100011,
      OPC_B_TYPE = 7'b1100011,
      OPC_U_LUI  = 7'b0110111,
      OPC_U_AUI  = 7'b0010111,
      OPC_I_JALR = 7'b1100111,
      OPC_J_TYPE = 7'b1101111
   } RV32I_OPCODE_t;

   typedef enum logic [2:0] {
      CU_FETCH,
      CU_DECODE,
      CU_EXECUTE,
      CU_MEM,
      CU_WB,
      CU_TRAP
   } cu_state_t;

   typedef enum logic [1:0] {
      TRAP_NONE,
      TRAP_ILLEGAL_OPCODE,
      TRAP_BUS_TIMEOUT
   } cu_trap_t;

   function automatic logic is_legal_opcode(input RV32I_OPCODE_t op);
      case (op)
         OPC_R_TYPE, OPC_I_TYPE, OPC_I_LOAD, OPC_S_TYPE, OPC_B_TYPE,
         OPC_U_LUI, OPC_U_AUI, OPC_I_JALR, OPC_J_TYPE: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts consecutive unacknowledged bus cycles; flags the last allowed one.
// BUS_TIMEOUT of 0 disables expiry; the counter saturates instead of wrapping.
module bus_wait_timer #(
   parameter int unsigned BUS_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic waiting,
   output logic expired
);

   localparam int unsigned CNT_W = (BUS_TIMEOUT < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'((BUS_TIMEOUT > 0) ? (BUS_TIMEOUT - 1) : 0);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (waiting && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = (BUS_TIMEOUT != 0) && waiting && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a
// req/ack bus handshake, bus timeout and a sticky TRAP state.
module multicycle_control_unit
   import fe_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  RV32I_OPCODE_t opcode,
   input  logic          bus_ack,
   output logic          bus_addr_select_alu_out,
   output logic          bus_rden,
   output logic          bus_wren,
   output logic          ir_wren,
   output logic          mdr_wren,
   output logic          pc_wren,
   output logic          rf_wren,
   output cu_state_t     state_o,
   output logic          instr_retired,
   output logic          trap,
   output cu_trap_t      trap_cause
);

   cu_state_t state_q, state_d;
   cu_trap_t  cause_q, cause_d;
   logic      rden_q, wren_q, asel_q, trap_q;
   logic      in_bus, expired, run;
   logic      is_load, is_store, is_branch;

   assign is_load   = (opcode == OPC_I_LOAD);
   assign is_store  = (opcode == OPC_S_TYPE);
   assign is_branch = (opcode == OPC_B_TYPE);
   assign in_bus    = (state_q == CU_FETCH) || (state_q == CU_MEM);
   assign run       = ~rst;

   // Clearing whenever outside a bus phase covers every entry into FETCH/MEM.
   bus_wait_timer #(
      .BUS_TIMEOUT(BUS_TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (~in_bus | bus_ack),
      .waiting(in_bus & ~bus_ack),
      .expired(expired)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      unique case (state_q)
         CU_FETCH: begin
            if (bus_ack) begin
               state_d = CU_DECODE;
            end else if (expired) begin
               state_d = CU_TRAP;
               cause_d = TRAP_BUS_TIMEOUT;
            end
         end
         CU_DECODE: begin
            if (is_legal_opcode(opcode)) begin
               state_d = CU_EXECUTE;
            end else begin
               state_d = CU_TRAP;
               cause_d = TRAP_ILLEGAL_OPCODE;
            end
         end
         CU_EXECUTE: begin
            if (is_load || is_store) state_d = CU_MEM;
            else if (is_branch)      state_d = CU_FETCH;
            else                     state_d = CU_WB;
         end
         CU_MEM: begin
            if (bus_ack) begin
               state_d = is_load ? CU_WB : CU_FETCH;
            end else if (expired) begin
               state_d = CU_TRAP;
               cause_d = TRAP_BUS_TIMEOUT;
            end
         end
         CU_WB:   state_d = CU_FETCH;
         CU_TRAP: state_d = CU_TRAP;
         default: state_d = CU_FETCH;
      endcase
   end

   // Bus request/select outputs are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CU_FETCH;
         cause_q <= TRAP_NONE;
         trap_q  <= 1'b0;
         rden_q  <= 1'b1;
         wren_q  <= 1'b0;
         asel_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         trap_q  <= (state_d == CU_TRAP);
         rden_q  <= (state_d == CU_FETCH) || ((state_d == CU_MEM) && is_load);
         wren_q  <= (state_d == CU_MEM) && is_store;
         asel_q  <= (state_d == CU_MEM);
      end
   end

   assign bus_rden                = run & rden_q;
   assign bus_wren                = run & wren_q;
   assign bus_addr_select_alu_out = run & asel_q;

   assign ir_wren  = run & (state_q == CU_FETCH) & bus_ack;
   assign mdr_wren = run & (state_q == CU_MEM) & is_load & bus_ack;
   assign rf_wren  = run & (state_q == CU_WB);
   assign pc_wren  = run & (((state_q == CU_EXECUTE) & is_branch) |
                            ((state_q == CU_MEM) & is_store & bus_ack) |
                            (state_q == CU_WB));
   assign instr_retired = pc_wren;

   assign state_o    = state_q;
   assign trap       = trap_q;
   assign trap_cause = cause_q;

   a_rd_wr_exclusive: assert property (@(posedge clk) !(bus_rden && bus_wren));

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Phase-level model of the control unit; every cycle's outputs are compared.
module tb_multicycle_control_unit;
   import fe_pkg::*;

   localparam int unsigned T = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          bus_ack;
   RV32I_OPCODE_t opcode;
   logic          bus_addr_select_alu_out, bus_rden, bus_wren, ir_wren;
   logic          mdr_wren, pc_wren, rf_wren, instr_retired, trap;
   cu_state_t     state_o;
   cu_trap_t      trap_cause;

   always #5 clk = ~clk;

   multicycle_control_unit #(.BUS_TIMEOUT(T)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .opcode                 (opcode),
      .bus_ack                (bus_ack),
      .bus_addr_select_alu_out(bus_addr_select_alu_out),
      .bus_rden               (bus_rden),
      .bus_wren               (bus_wren),
      .ir_wren                (ir_wren),
      .mdr_wren               (mdr_wren),
      .pc_wren                (pc_wren),
      .rf_wren                (rf_wren),
      .state_o                (state_o),
      .instr_retired          (instr_retired),
      .trap                   (trap),
      .trap_cause             (trap_cause)
   );

   typedef struct {
      logic      chk_state;
      cu_state_t st;
      logic      rden, wren, asel, ir, mdr, pc, rf, ret, trap;
      cu_trap_t  cause;
   } exp_t;

   exp_t expq[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   retire_seen = 0;
   int   mdr_seen = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         cur = expq.pop_front();
         if (cur.chk_state) begin
            chk("state", int'(state_o), int'(cur.st));
            chk("trap", int'(trap), int'(cur.trap));
            chk("trap_cause", int'(trap_cause), int'(cur.cause));
         end
         chk("bus_rden", int'(bus_rden), int'(cur.rden));
         chk("bus_wren", int'(bus_wren), int'(cur.wren));
         chk("addr_sel", int'(bus_addr_select_alu_out), int'(cur.asel));
         chk("ir_wren", int'(ir_wren), int'(cur.ir));
         chk("mdr_wren", int'(mdr_wren), int'(cur.mdr));
         chk("pc_wren", int'(pc_wren), int'(cur.pc));
         chk("rf_wren", int'(rf_wren), int'(cur.rf));
         chk("retired", int'(instr_retired), int'(cur.ret));
      end
      if (instr_retired) retire_seen++;
      if (mdr_wren) mdr_seen++;
   end

   function automatic exp_t mk(input cu_state_t st, input logic rd, input logic wr,
                               input logic ir, input logic mdr, input logic pc, input logic rf);
      exp_t e;
      e.chk_state = 1'b1;
      e.st    = st;
      e.rden  = rd;
      e.wren  = wr;
      e.asel  = (st == CU_MEM);
      e.ir    = ir;
      e.mdr   = mdr;
      e.pc    = pc;
      e.rf    = rf;
      e.ret   = pc;
      e.trap  = (st == CU_TRAP);
      e.cause = TRAP_NONE;
      return e;
   endfunction

   function automatic logic tb_legal(input RV32I_OPCODE_t op);
      return op inside {OPC_R_TYPE, OPC_I_TYPE, OPC_I_LOAD, OPC_S_TYPE, OPC_B_TYPE,
                        OPC_U_LUI, OPC_U_AUI, OPC_I_JALR, OPC_J_TYPE};
   endfunction

   task automatic step(input logic ack, input exp_t e);
      bus_ack = ack;
      expq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         rst = 1'b1;
         e = mk(CU_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         e.chk_state = (i != 0);
         step(1'b0, e);
      end
      rst = 1'b0;
   endtask

   task automatic trap_phase(input cu_trap_t cause, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e = mk(CU_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         e.cause = cause;
         step(i[0], e);
      end
   endtask

   // One bus access: w wait cycles then ack, unless T unacked cycles elapse first.
   task automatic bus_phase(input cu_state_t st, input logic rd, input logic wr,
                            input int w, inout int cyc, output logic timed_out);
      logic a;
      logic fetch;
      fetch = (st == CU_FETCH);
      timed_out = 1'b0;
      for (int i = 0; i <= w; i++) begin
         a = (i == w);
         step(a, mk(st, rd, wr, fetch & a, ~fetch & rd & a, ~fetch & wr & a, 1'b0));
         cyc++;
         if (!a && (T > 0) && (i == int'(T) - 1)) begin
            timed_out = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_instr(input RV32I_OPCODE_t op, input int fw, input int mw,
                            input logic noise, output int cyc);
      logic to;
      logic ld, stv;
      exp_t z;
      ld  = (op == OPC_I_LOAD);
      stv = (op == OPC_S_TYPE);
      cyc = 0;
      opcode = op;
      bus_phase(CU_FETCH, 1'b1, 1'b0, fw, cyc, to);
      if (to) begin
         trap_phase(TRAP_BUS_TIMEOUT, 3);
         return;
      end
      z = mk(CU_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(noise, z);
      cyc++;
      if (!tb_legal(op)) begin
         trap_phase(TRAP_ILLEGAL_OPCODE, 20);
         return;
      end
      step(noise, mk(CU_EXECUTE, 1'b0, 1'b0, 1'b0, 1'b0, op == OPC_B_TYPE, 1'b0));
      cyc++;
      if (op == OPC_B_TYPE) return;
      if (ld || stv) begin
         bus_phase(CU_MEM, ld, stv, mw, cyc, to);
         if (to) begin
            trap_phase(TRAP_BUS_TIMEOUT, 3);
            return;
         end
         if (stv) return;
      end
      step(noise, mk(CU_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      int cyc;
      int mdr0;
      exp_t e;
      rst = 1'b1;
      bus_ack = 1'b0;
      opcode = OPC_R_TYPE;
      @(posedge clk);
      #1;
      do_reset(2);

      run_instr(OPC_R_TYPE, 0, 0, 1'b0, cyc); chk("lat_add", cyc, 4);
      mdr0 = mdr_seen;
      run_instr(OPC_I_LOAD, 2, 1, 1'b0, cyc); chk("lat_lw_waits", cyc, 8);
      chk("lw_mdr_pulses", mdr_seen - mdr0, 1);
      run_instr(OPC_S_TYPE, 0, 0, 1'b0, cyc); chk("lat_sw", cyc, 4);
      run_instr(OPC_B_TYPE, 0, 0, 1'b0, cyc); chk("lat_beq", cyc, 3);
      run_instr(OPC_J_TYPE, 1, 0, 1'b1, cyc); chk("lat_jal_wait", cyc, 5);
      run_instr(OPC_U_LUI, 0, 0, 1'b1, cyc); chk("lat_lui", cyc, 4);
      run_instr(OPC_I_LOAD, 0, 0, 1'b1, cyc); chk("lat_lw", cyc, 5);

      run_instr(RV32I_OPCODE_t'(7'h00), 0, 0, 1'b0, cyc);
      do_reset(2);
      run_instr(OPC_R_TYPE, 0, 0, 1'b0, cyc); chk("lat_add_after_trap", cyc, 4);

      // Store stalled in MEM, then reset lands mid-access.
      opcode = OPC_S_TYPE;
      step(1'b1, mk(CU_FETCH, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      step(1'b0, mk(CU_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      step(1'b0, mk(CU_EXECUTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      step(1'b0, mk(CU_MEM, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      do_reset(1);
      run_instr(OPC_R_TYPE, 0, 0, 1'b0, cyc); chk("lat_add_after_rst", cyc, 4);

      run_instr(OPC_R_TYPE, 10, 0, 1'b0, cyc);
      do_reset(2);
      run_instr(OPC_I_TYPE, 3, 0, 1'b0, cyc); chk("lat_fetch_last_ack", cyc, 7);

      run_instr(OPC_S_TYPE, 0, 10, 1'b0, cyc);
      do_reset(2);
      run_instr(OPC_I_LOAD, 0, 3, 1'b0, cyc); chk("lat_mem_last_ack", cyc, 8);

      e = mk(CU_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, e);
      chk("retired_total", retire_seen, 11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
